// File: rtl/sequence_detector_pkg.sv
// Shared types and constants for the 1110 serial pattern detector.
package sequence_detector_pkg;

  localparam int unsigned SEQ_STATE_W = 3;
  localparam int unsigned SEQ_PAT_W   = 4;

  // Pattern watched for, first bit in the MSB.
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1110;

  // Detector states; encodings 5..7 are unused and recover to idle.
  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE = 3'd0,
    SEQ_1    = 3'd1,
    SEQ_11   = 3'd2,
    SEQ_111  = 3'd3,
    SEQ_DET  = 3'd4
  } seq_state_t;

endpackage : sequence_detector_pkg

// File: rtl/sequence_detector_if.sv
// Serial bit in / detect flag out for the 1110 pattern detector.
interface sequence_detector_if;

  logic X;
  logic Y;

  // Source of the bit stream, consumer of the flag.
  modport master (output X, input Y);

  // The detector itself.
  modport slave (input X, output Y);

endinterface : sequence_detector_if

// File: rtl/sequence_detector.sv
// Serial detector for the bit pattern 1110 on bus.X, flag on bus.Y.
// Build option: define SEQ_DET_MEALY_EN for a Mealy flag that rises in the
// same cycle as the final 0; default is a Moore flag one cycle later.
module sequence_detector
  import sequence_detector_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sequence_detector_if.slave  bus
);

  localparam logic [SEQ_STATE_W-1:0] S_IDLE = SEQ_IDLE;
  localparam logic [SEQ_STATE_W-1:0] S_1    = SEQ_1;
  localparam logic [SEQ_STATE_W-1:0] S_11   = SEQ_11;
  localparam logic [SEQ_STATE_W-1:0] S_111  = SEQ_111;
`ifndef SEQ_DET_MEALY_EN
  localparam logic [SEQ_STATE_W-1:0] S_DET  = SEQ_DET;
`endif

  logic [SEQ_STATE_W-1:0] state_q;
  logic [SEQ_STATE_W-1:0] state_d;

  // State register; reset discards any partial prefix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall through to idle.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = bus.X ? S_1   : S_IDLE;
      S_1:     state_d = bus.X ? S_11  : S_IDLE;
      S_11:    state_d = bus.X ? S_111 : S_IDLE;
`ifdef SEQ_DET_MEALY_EN
      // Detection is flagged combinationally, so the final 0 returns to idle.
      S_111:   state_d = bus.X ? S_111 : S_IDLE;
`else
      S_111:   state_d = bus.X ? S_111 : S_DET;
      // A trailing 0 is never a prefix of 1110, so the search restarts.
      S_DET:   state_d = bus.X ? S_1   : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SEQ_DET_MEALY_EN

  // Mealy flag: final 0 seen while in the 111 state, held low in reset.
  assign bus.Y = rst && (state_q == S_111) && !bus.X;

`else

  logic y_q;

  // Moore flag registered alongside the state so it equals (state == S_DET).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q <= 1'b0;
    end else begin
      y_q <= (state_d == S_DET);
    end
  end

  assign bus.Y = y_q;

`endif

endmodule : sequence_detector

// File: tb/tb_sequence_detector.sv
// Self-checking bench for sequence_detector (Moore default, Mealy with SEQ_DET_MEALY_EN).
module tb_sequence_detector;
  import sequence_detector_pkg::*;

  logic clk;
  logic rst;

  sequence_detector_if bus ();

  sequence_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: the last four bits sampled since reset, and how many.
  logic [3:0] hist;
  int         nvalid;

  // Expected flag at the check point, with bit b currently on X.
  function automatic logic exp_y(logic b);
`ifdef SEQ_DET_MEALY_EN
    return rst && (nvalid >= 3) && (hist[2:0] == SEQ_PATTERN[3:1]) && (b == SEQ_PATTERN[0]);
`else
    return (nvalid >= 4) && (hist == SEQ_PATTERN);
`endif
  endfunction

  task automatic model_clear();
    hist   = 4'b0000;
    nvalid = 0;
  endtask

  // Present the next bit half a cycle before the sampling edge.
  task automatic set_x(logic b);
    @(negedge clk);
    bus.X = b;
    #1;
  endtask

  // Let the edge sample X and advance the model.
  task automatic clock_in(logic b);
    @(posedge clk);
    if (rst) begin
      hist   = {hist[2:0], b};
      nvalid = nvalid + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    bus.X = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.Y !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: Y=%b expected 0", bus.Y);
    end
    for (int i = 0; i < 4; i++) begin
      set_x(i[0] ? 1'b0 : 1'b1);
      checks++;
      if (bus.Y !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: Y=%b expected 0", i, bus.Y);
      end
      clock_in(bus.X);
    end
    @(negedge clk);
    rst   = 1'b1;
    bus.X = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    logic [7:0] seq;
    int pulses;
    seq    = 8'b1110_0000;
    pulses = 0;
    for (int i = 7; i >= 2; i--) begin
      set_x(seq[i]);
      checks++;
      if (bus.Y !== exp_y(seq[i])) begin
        errors++;
        $display("FAIL basic bit %0d: Y=%b expected %b", 7 - i, bus.Y, exp_y(seq[i]));
      end
      if (bus.Y === 1'b1) pulses++;
      clock_in(seq[i]);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL basic_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_frames();
    logic [15:0] seq;
    int pulses;
    seq    = 16'b1110_0111_0011_1000;
    pulses = 0;
    for (int i = 15; i >= 1; i--) begin
      set_x(seq[i]);
      checks++;
      if (bus.Y !== exp_y(seq[i])) begin
        errors++;
        $display("FAIL frames bit %0d: Y=%b expected %b", 15 - i, bus.Y, exp_y(seq[i]));
      end
      if (bus.Y === 1'b1) pulses++;
      clock_in(seq[i]);
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL frames_pulses: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_long_run();
    logic [15:0] seq;
    int pulses;
    // 1,1,1,1,1,0,0 then 1,1,0,1,1,1,0,0 : one pulse each
    seq    = 16'b1111_1001_1011_1000;
    pulses = 0;
    for (int i = 15; i >= 1; i--) begin
      set_x(seq[i]);
      checks++;
      if (bus.Y !== exp_y(seq[i])) begin
        errors++;
        $display("FAIL long_run bit %0d: Y=%b expected %b", 15 - i, bus.Y, exp_y(seq[i]));
      end
      if (bus.Y === 1'b1) pulses++;
      clock_in(seq[i]);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL long_run_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    int pulses;
    seq    = 16'b1110_1110_1110_0000;
    pulses = 0;
    for (int i = 15; i >= 2; i--) begin
      set_x(seq[i]);
      checks++;
      if (bus.Y !== exp_y(seq[i])) begin
        errors++;
        $display("FAIL back_to_back bit %0d: Y=%b expected %b", 15 - i, bus.Y, exp_y(seq[i]));
      end
      if (bus.Y === 1'b1) pulses++;
      clock_in(seq[i]);
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL back_to_back_pulses: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq;
    int pulses;
    for (int i = 0; i < 3; i++) begin
      set_x(1'b1);
      clock_in(1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.Y !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_assert: Y=%b expected 0", bus.Y);
    end
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    bus.X = 1'b0;
    #1;
    pulses = 0;
    checks++;
    if (bus.Y !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: Y=%b expected 0", bus.Y);
    end
    clock_in(1'b0);
    seq = 8'b0111_0000;
    for (int i = 7; i >= 2; i--) begin
      set_x(seq[i]);
      checks++;
      if (bus.Y !== exp_y(seq[i])) begin
        errors++;
        $display("FAIL mid_reset bit %0d: Y=%b expected %b", 7 - i, bus.Y, exp_y(seq[i]));
      end
      if (bus.Y === 1'b1) pulses++;
      clock_in(seq[i]);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL mid_reset_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_random();
    logic b;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.Y !== 1'b0) begin
          errors++;
          $display("FAIL random_reset step %0d: Y=%b expected 0", n, bus.Y);
        end
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        bus.X = 1'b0;
        #1;
        clock_in(1'b0);
      end else begin
        b = ($urandom_range(0, 3) != 0);
        set_x(b);
        checks++;
        if (bus.Y !== exp_y(b)) begin
          errors++;
          $display("FAIL random step %0d: X=%b Y=%b expected %b", n, b, bus.Y, exp_y(b));
        end
        clock_in(b);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_frames();
    test_long_run();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_sequence_detector
